// File: rtl/out_serializer_pkg.sv
// out_ser_pkg: shared definitions for the out_serializer transmitter.
//   state_t   : FSM state encoding (IDLE/START/DATA/STOP)
//   DATA_W    : parallel data width
//   *_LVL     : serial line levels for start, stop and idle
package out_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int DATA_W = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/out_serializer_if.sv
// out_serializer_if: bus-side signals of the output serializer.
//   D_in    : parallel byte from the bus
//   load    : capture strobe (OI)
//   ser_out : serial line, idles high
//   busy    : frame in progress
//   done    : one-cycle pulse when a frame completes
//   ovf     : one-cycle pulse when a load is dropped
// Modports: master drives D_in/load, slave is the serializer.
interface out_serializer_if;
  import out_ser_pkg::*;

  logic [DATA_W-1:0] D_in;
  logic              load;
  logic              ser_out;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output D_in,
    output load,
    input  ser_out,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  D_in,
    input  load,
    output ser_out,
    output busy,
    output done,
    output ovf
  );

endinterface

// File: rtl/out_bit_timer.sv
// out_bit_timer: bit-period divider for the serializer.
//   clk     : system clock
//   clear   : asynchronous active-high reset (counter to 0)
//   restart : synchronous restart, holds the counter at 0 and masks tick
//   tick    : high in the last cycle of each CLKS_PER_BIT-cycle bit period
module out_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_reg;

  // With CLKS_PER_BIT=1 the counter sits at 0 and tick is high every
  // cycle the timer is not held in restart.
  assign tick = (cnt_reg == LAST) && !restart;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_reg <= 8'd0;
    end else if (restart || (cnt_reg == LAST)) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/out_serializer.sv
// out_serializer: parallel-in, serial-out transmitter for the output port.
// Frame: start bit (0), 8 data bits LSB-first, STOP_BITS stop bits (1).
//   clk   : system clock, rising edge
//   clear : asynchronous active-high reset
//   bus   : out_serializer_if.slave (D_in, load, ser_out, busy, done, ovf)
// Parameters: CLKS_PER_BIT (1..255), STOP_BITS (1 or 2).
// Optional build macro OUT_HOLD_EN: one-entry holding register so a load
// taken during a frame is sent immediately after it instead of dropped.
module out_serializer
  import out_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic clear,
  out_serializer_if.slave bus
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [2:0]        bit_cnt_reg;
  logic              ser_out_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              ovf_reg;
  logic              tick;

`ifdef OUT_HOLD_EN
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full_reg;
`endif

  // Divider is held at zero while idle so the start bit gets a full period.
  out_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .clear   (clear),
    .restart (state_reg == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= 3'd0;
      ser_out_reg <= IDLE_LVL;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
`ifdef OUT_HOLD_EN
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      ovf_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
`ifdef OUT_HOLD_EN
          // A byte parked in the hold on the final stop edge is sent first;
          // a simultaneous load refills the hold slot being vacated.
          if (hold_full_reg) begin
            shreg_reg     <= hold_reg;
            state_reg     <= START;
            ser_out_reg   <= START_LVL;
            busy_reg      <= 1'b1;
            bit_cnt_reg   <= 3'd0;
            if (bus.load) begin
              hold_reg <= bus.D_in;
            end else begin
              hold_full_reg <= 1'b0;
            end
          end else
`endif
          if (bus.load) begin
            shreg_reg   <= bus.D_in;
            state_reg   <= START;
            ser_out_reg <= START_LVL;
            busy_reg    <= 1'b1;
            bit_cnt_reg <= 3'd0;
          end
        end

        START: begin
          if (tick) begin
            state_reg   <= DATA;
            ser_out_reg <= shreg_reg[0];
          end
        end

        DATA: begin
          if (tick) begin
            shreg_reg   <= shreg_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;  // 7 -> 0 reuses it for stop bits
            if (bit_cnt_reg == 3'd7) begin
              state_reg   <= STOP;
              ser_out_reg <= STOP_LVL;
            end else begin
              // Registered output: present the bit that becomes shreg[0].
              ser_out_reg <= shreg_reg[1];
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (bit_cnt_reg == STOP_LAST) begin
              done_reg <= 1'b1;
`ifdef OUT_HOLD_EN
              if (hold_full_reg) begin
                shreg_reg     <= hold_reg;
                hold_full_reg <= 1'b0;
                state_reg     <= START;
                ser_out_reg   <= START_LVL;
                bit_cnt_reg   <= 3'd0;
              end else
`endif
              begin
                state_reg   <= IDLE;
                ser_out_reg <= IDLE_LVL;
                busy_reg    <= 1'b0;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase

      // Loads arriving mid-frame never disturb the frame in flight.
      if (bus.load && (state_reg != IDLE)) begin
`ifdef OUT_HOLD_EN
        if (hold_full_reg) begin
          ovf_reg <= 1'b1;
        end else begin
          hold_reg      <= bus.D_in;
          hold_full_reg <= 1'b1;
        end
`else
        ovf_reg <= 1'b1;
`endif
      end
    end
  end

  assign bus.ser_out = ser_out_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.ovf     = ovf_reg;

endmodule

// File: tb/tb_out_serializer.sv
// tb_out_serializer: directed self-checking bench for out_serializer.
// dut_a uses CLKS_PER_BIT=4/STOP_BITS=1, dut_b uses CLKS_PER_BIT=1/STOP_BITS=2.
// Cycle c is the clock period following edge c-1; edge 0 samples the load.
module tb_out_serializer;

  logic clk;
  logic clear;
  int   errors;
  int   checks;

  out_serializer_if ifa ();
  out_serializer_if ifb ();

  out_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk   (clk),
    .clear (clear),
    .bus   (ifa.slave)
  );

  out_serializer #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .clk   (clk),
    .clear (clear),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level in cycle c of a frame whose load was taken at edge 0.
  function automatic logic exp_line(input logic [7:0] b, input int c,
                                    input int cpb, input int sb);
    int idx;
    if (c < 1 || c > (9 + sb) * cpb) return 1'b1;
    if (c <= cpb) return 1'b0;
    if (c <= 9 * cpb) begin
      idx = (c - 1) / cpb - 1;
      return b[idx[2:0]];
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int c, input int cpb, input int sb);
    return (c >= 1) && (c <= (9 + sb) * cpb);
  endfunction

  task automatic test_reset();
    clear = 1'b1;
    ifa.load = 1'b0; ifa.D_in = 8'h00;
    ifb.load = 1'b0; ifb.D_in = 8'h00;
    repeat (2) @(negedge clk);
    checks += 8;
    if (ifa.ser_out !== 1'b1) begin errors++; $display("FAIL reset_a_ser_out got %b exp 1", ifa.ser_out); end
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b exp 0", ifa.busy); end
    if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_a_done got %b exp 0", ifa.done); end
    if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL reset_a_ovf got %b exp 0", ifa.ovf); end
    if (ifb.ser_out !== 1'b1) begin errors++; $display("FAIL reset_b_ser_out got %b exp 1", ifb.ser_out); end
    if (ifb.busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %b exp 0", ifb.busy); end
    if (ifb.done !== 1'b0) begin errors++; $display("FAIL reset_b_done got %b exp 0", ifb.done); end
    if (ifb.ovf !== 1'b0) begin errors++; $display("FAIL reset_b_ovf got %b exp 0", ifb.ovf); end
    clear = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_reset: outputs idle after clear");
  endtask

  task automatic test_basic_frame();
    ifa.D_in = 8'hA5; ifa.load = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      ifa.load = 1'b0;
      checks += 4;
      if (ifa.ser_out !== exp_line(8'hA5, c, 4, 1)) begin errors++; $display("FAIL basic_ser_out c=%0d got %b exp %b", c, ifa.ser_out, exp_line(8'hA5, c, 4, 1)); end
      if (ifa.busy !== exp_busy(c, 4, 1)) begin errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, ifa.busy, exp_busy(c, 4, 1)); end
      if (ifa.done !== (c == 41)) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, ifa.done, (c == 41)); end
      if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf c=%0d got %b exp 0", c, ifa.ovf); end
    end
    $display("test_basic_frame: byte A5 framed over 40 cycles");
  endtask

  task automatic test_loopback();
    logic [7:0] sipo;
    sipo = 8'h00;
    ifa.D_in = 8'h3C; ifa.load = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      ifa.load = 1'b0;
      // Data bit i is centred in cycle 7+4i; receiver shifts right, MSB-in.
      if (c >= 7 && c <= 35 && ((c - 7) % 4) == 0) sipo = {ifa.ser_out, sipo[7:1]};
    end
    checks++;
    if (sipo !== 8'h3C) begin errors++; $display("FAIL loopback got %h exp 3c", sipo); end
    $display("test_loopback: sipo=%h", sipo);
  endtask

  task automatic test_dropped_load();
    logic exp_l, exp_b, exp_d;
    int   last;
`ifdef OUT_HOLD_EN
    last = 85;
`else
    last = 50;
`endif
    ifa.D_in = 8'h5A; ifa.load = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      ifa.load = 1'b0;
`ifdef OUT_HOLD_EN
      exp_l = (c <= 40) ? exp_line(8'h5A, c, 4, 1) : exp_line(8'h0F, c - 40, 4, 1);
      exp_b = (c >= 1 && c <= 80);
      exp_d = (c == 41) || (c == 81);
`else
      exp_l = exp_line(8'h5A, c, 4, 1);
      exp_b = exp_busy(c, 4, 1);
      exp_d = (c == 41);
`endif
      checks += 4;
      if (ifa.ser_out !== exp_l) begin errors++; $display("FAIL drop_ser_out c=%0d got %b exp %b", c, ifa.ser_out, exp_l); end
      if (ifa.busy !== exp_b) begin errors++; $display("FAIL drop_busy c=%0d got %b exp %b", c, ifa.busy, exp_b); end
      if (ifa.done !== exp_d) begin errors++; $display("FAIL drop_done c=%0d got %b exp %b", c, ifa.done, exp_d); end
      if (ifa.ovf !== (c == 11)) begin errors++; $display("FAIL drop_ovf c=%0d got %b exp %b", c, ifa.ovf, (c == 11)); end
`ifdef OUT_HOLD_EN
      if (c == 8) begin ifa.D_in = 8'h0F; ifa.load = 1'b1; end
      if (c == 10) begin ifa.D_in = 8'h33; ifa.load = 1'b1; end
`else
      if (c == 10) begin ifa.D_in = 8'h0F; ifa.load = 1'b1; end
`endif
    end
    $display("test_dropped_load: ovf pulse in cycle 11, frame intact");
  endtask

  task automatic test_reset_mid_frame();
    ifa.D_in = 8'h00; ifa.load = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ifa.load = 1'b0;
    end
    checks += 2;
    if (ifa.ser_out !== 1'b0) begin errors++; $display("FAIL midrst_pre_ser_out got %b exp 0", ifa.ser_out); end
    if (ifa.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b exp 1", ifa.busy); end
    #1 clear = 1'b1;
    #1;
    checks += 2;
    if (ifa.ser_out !== 1'b1) begin errors++; $display("FAIL midrst_ser_out got %b exp 1", ifa.ser_out); end
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", ifa.busy); end
    @(negedge clk);
    clear = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks += 3;
      if (ifa.ser_out !== 1'b1) begin errors++; $display("FAIL midrst_idle_ser_out c=%0d got %b exp 1", c, ifa.ser_out); end
      if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy c=%0d got %b exp 0", c, ifa.busy); end
      if (ifa.done !== 1'b0) begin errors++; $display("FAIL midrst_idle_done c=%0d got %b exp 0", c, ifa.done); end
    end
    $display("test_reset_mid_frame: line high immediately, stays idle");
  endtask

  task automatic test_back_to_back();
    logic exp_l, exp_b, exp_d, exp_o;
    ifa.D_in = 8'h81; ifa.load = 1'b1;
    for (int c = 1; c <= 85; c++) begin
      @(negedge clk);
`ifdef OUT_HOLD_EN
      ifa.load = (c == 15);
      if (c == 15) ifa.D_in = 8'h42;
      exp_l = (c <= 40) ? exp_line(8'h81, c, 4, 1) : exp_line(8'h42, c - 40, 4, 1);
      exp_b = (c >= 1 && c <= 80);
      exp_d = (c == 41) || (c == 81);
      exp_o = 1'b0;
`else
      if (c == 50) ifa.load = 1'b0;
      exp_l = (c <= 41) ? exp_line(8'h81, c, 4, 1) : exp_line(8'h81, c - 41, 4, 1);
      exp_b = (c >= 1 && c <= 40) || (c >= 42 && c <= 81);
      exp_d = (c == 41) || (c == 82);
      // Load is high at edges 0..49; each one taken while busy is dropped.
      exp_o = ((c - 1 >= 1 && c - 1 <= 40) || (c - 1 >= 42 && c - 1 <= 81)) && (c - 1 <= 49);
`endif
      checks += 4;
      if (ifa.ser_out !== exp_l) begin errors++; $display("FAIL b2b_ser_out c=%0d got %b exp %b", c, ifa.ser_out, exp_l); end
      if (ifa.busy !== exp_b) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, ifa.busy, exp_b); end
      if (ifa.done !== exp_d) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, ifa.done, exp_d); end
      if (ifa.ovf !== exp_o) begin errors++; $display("FAIL b2b_ovf c=%0d got %b exp %b", c, ifa.ovf, exp_o); end
    end
    $display("test_back_to_back: two frames checked");
  endtask

  task automatic test_param_corner();
    ifb.D_in = 8'hFF; ifb.load = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      ifb.load = 1'b0;
      checks += 3;
      if (ifb.ser_out !== exp_line(8'hFF, c, 1, 2)) begin errors++; $display("FAIL corner_ser_out c=%0d got %b exp %b", c, ifb.ser_out, exp_line(8'hFF, c, 1, 2)); end
      if (ifb.busy !== exp_busy(c, 1, 2)) begin errors++; $display("FAIL corner_busy c=%0d got %b exp %b", c, ifb.busy, exp_busy(c, 1, 2)); end
      if (ifb.done !== (c == 12)) begin errors++; $display("FAIL corner_done c=%0d got %b exp %b", c, ifb.done, (c == 12)); end
    end
    $display("test_param_corner: CLKS_PER_BIT=1 STOP_BITS=2 frame of 11 cycles");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear  = 1'b1;
    test_reset();
    @(negedge clk);
    test_basic_frame();
    repeat (3) @(negedge clk);
    test_loopback();
    repeat (3) @(negedge clk);
    test_dropped_load();
    repeat (3) @(negedge clk);
    test_reset_mid_frame();
    @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_param_corner();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
